// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller for the MEM stage of a 5-stage pipeline.
// Stalls the pipeline while a load miss is refilled from main memory or a
// write-through store drains, with a per-transaction timeout that aborts
// to DONE and raises a sticky bus error.
module dcache_miss_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             data_hit,
    input  logic             mem_ready,
    output logic             stall,
    output logic             wb_bubble,
    output logic             mem_req,
    output logic             mem_we,
    output logic             refill,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             bus_err
);

    typedef enum logic [2:0] {
        StIdle,
        StRdMiss,
        StWrite,
        StFill,
        StDone
    } state_t;

    // Last wait-counter value before abort: the counter holds (cycles waited - 1).
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        idle_leave;

    // A store always leaves IDLE (write has priority); a load leaves only on a miss.
    assign idle_leave = mem_write | (mem_read & ~data_hit);

    // State, wait counter, miss counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            wait_cnt <= '0;
            miss_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    // RD_MISS and WRITE are only entered from here, so this clears on entry.
                    wait_cnt <= '0;
                    if (mem_write) begin
                        state <= StWrite;
                    end else if (mem_read && !data_hit) begin
                        state <= StRdMiss;
                        if (miss_cnt != '1) begin
                            miss_cnt <= miss_cnt + CNT_W'(1);
                        end
                    end
                end
                StRdMiss: begin
                    if (mem_ready) begin
                        state <= StFill;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= StDone;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                StWrite: begin
                    if (mem_ready) begin
                        state <= StDone;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= StDone;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                StFill: state <= StDone;
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Pipeline and memory controls decoded from state; forced low while in reset.
    always_comb begin
        stall   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        refill  = 1'b0;
        if (!rst) begin
            unique case (state)
                StIdle:   stall = idle_leave;
                StRdMiss: begin
                    stall   = 1'b1;
                    mem_req = 1'b1;
                end
                StWrite: begin
                    stall   = 1'b1;
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
                StFill: begin
                    stall  = 1'b1;
                    refill = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wb_bubble = stall;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: the driver applies one directed
// vector per cycle and queues its hand-computed response; a monitor pops
// and compares on the falling edge.
module tb_dcache_miss_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             mem_read;
    logic             mem_write;
    logic             data_hit;
    logic             mem_ready;
    logic             stall;
    logic             wb_bubble;
    logic             mem_req;
    logic             mem_we;
    logic             refill;
    logic [CNT_W-1:0] miss_cnt;
    logic             bus_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       stall;
        logic       req;
        logic       we;
        logic       refill;
        logic [1:0] cnt;
        logic       err;
        bit         ck_state;
    } exp_t;

    exp_t sb[$];

    dcache_miss_ctrl #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .data_hit (data_hit),
        .mem_ready(mem_ready),
        .stall    (stall),
        .wb_bubble(wb_bubble),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .refill   (refill),
        .miss_cnt (miss_cnt),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string sig, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", name, sig, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the response expected during that cycle.
    task automatic v(input string name, input logic r, input logic rd, input logic wr,
                     input logic hit, input logic rdy, input logic e_st, input logic e_rq,
                     input logic e_we, input logic e_rf, input int e_cnt, input logic e_err,
                     input bit ck = 1'b1);
        exp_t e;
        rst       = r;
        mem_read  = rd;
        mem_write = wr;
        data_hit  = hit;
        mem_ready = rdy;
        e.name     = name;
        e.stall    = e_st;
        e.req      = e_rq;
        e.we       = e_we;
        e.refill   = e_rf;
        e.cnt      = 2'(e_cnt);
        e.err      = e_err;
        e.ck_state = ck;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Back-to-back fast load miss: IDLE, RD_MISS (ready at once), FILL, DONE.
    task automatic fast_miss(input string name, input int c0, input int c1);
        v(name, 0, 1, 0, 0, 0, 1, 0, 0, 0, c0, 0);
        v(name, 0, 1, 0, 0, 1, 1, 1, 0, 0, c1, 0);
        v(name, 0, 1, 0, 1, 0, 1, 0, 0, 1, c1, 0);
        v(name, 0, 1, 0, 0, 0, 0, 0, 0, 0, c1, 0);
    endtask

    // Monitor: outputs are valid every cycle, so compare whenever a response is queued.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "stall", 16'(stall), 16'(e.stall));
            chk(e.name, "wb_bubble", 16'(wb_bubble), 16'(e.stall));
            chk(e.name, "mem_req", 16'(mem_req), 16'(e.req));
            chk(e.name, "mem_we", 16'(mem_we), 16'(e.we));
            chk(e.name, "refill", 16'(refill), 16'(e.refill));
            if (e.ck_state) begin
                chk(e.name, "miss_cnt", 16'(miss_cnt), 16'(e.cnt));
                chk(e.name, "bus_err", 16'(bus_err), 16'(e.err));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        data_hit  = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset: controls low even with a miss presented; state regs unknown in cycle 1.
        v("reset", 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1'b0);
        v("reset", 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);

        // Load hits never stall; mem_ready in IDLE is ignored.
        for (int i = 0; i < 5; i++) v("load_hit", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        v("idle_rdy", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        v("idle_rdy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load miss, ready on 3rd RD_MISS cycle: 5 stall cycles, one refill.
        v("ld_miss", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v("ld_miss", 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        v("ld_miss", 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        v("ld_miss", 0, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0);
        v("ld_miss", 0, 1, 0, 1, 1, 1, 0, 0, 1, 1, 0);
        // DONE ignores a store/miss on the inputs.
        v("ld_done", 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        v("ld_after", 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);

        // Store with read also set: WRITE path, ready on 2nd WRITE cycle, no count.
        v("store", 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0);
        v("store", 0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 0);
        v("store", 0, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0);
        v("st_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("st_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Store miss, ready at once.
        v("st_miss", 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        v("st_miss", 0, 0, 1, 0, 1, 1, 1, 1, 0, 1, 0);
        v("st_miss", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Timeout: 4 RD_MISS cycles without ready, then DONE with sticky bus_err.
        v("timeout", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) v("timeout", 0, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0);
        v("to_done", 0, 1, 0, 0, 1, 0, 0, 0, 0, 2, 1);
        for (int i = 0; i < 3; i++) v("to_sticky", 0, 1, 0, 1, 0, 0, 0, 0, 0, 2, 1);
        v("to_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        v("to_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in 2nd RD_MISS cycle abandons the miss; late ready ignored.
        v("abandon", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v("abandon", 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        v("ab_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v("ab_late", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        v("ab_late", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        v("ab_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Saturation at 3 with a 2-bit counter.
        fast_miss("sat1", 0, 1);
        fast_miss("sat2", 1, 2);
        fast_miss("sat3", 2, 3);
        fast_miss("sat4", 3, 3);
        fast_miss("sat5", 3, 3);
        v("sat_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses left, expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_miss_ctrl.md
DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, maximum mem_ready wait cycles per transaction before abort (1..65535).
REQ-002 Parameter: CNT_W, 16, width of miss_cnt.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- mem_read  in  1  MEM-stage load, from EX/MEM control
- mem_write  in  1  MEM-stage store, from EX/MEM control
- data_hit  in  1  data-cache hit for the current MEM-stage address
- mem_ready  in  1  main-memory completion strobe
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- wb_bubble  out  1  force MEM/WB control_wb to 2'b00 this cycle
- mem_req  out  1  main-memory request
- mem_we  out  1  main-memory write qualifier, valid with mem_req
- refill  out  1  data-cache line write enable
- miss_cnt  out  CNT_W  saturating read-miss count
- bus_err  out  1  sticky timeout flag

Function
REQ-005 The FSM SHALL have states IDLE, RD_MISS, WRITE, FILL and DONE.
REQ-006 Decoding in IDLE SHALL be as follows:
- mem_write=1 -> WRITE (write-through, no-allocate; write has priority if mem_read is also 1).
- else mem_read=1 and data_hit=0 -> RD_MISS, and miss_cnt increments.
- else stay in IDLE.
REQ-007 In RD_MISS, mem_req=1 and mem_we=0; on mem_ready=1 go to FILL, else stay.
REQ-008 In WRITE, mem_req=1 and mem_we=1; on mem_ready=1 go to DONE, else stay.
REQ-009 FILL SHALL last exactly one cycle with refill=1, then go to DONE.
REQ-010 DONE SHALL last exactly one cycle, ignore all inputs, then go to IDLE; this prevents the completed access from being decoded again.
REQ-011 stall SHALL be combinational, as follows:
- 1 in IDLE when the IDLE decode leaves IDLE (REQ-006).
- 1 in RD_MISS, WRITE and FILL.
- 0 in DONE, and 0 in IDLE on a hit or no access.
REQ-012 wb_bubble SHALL equal stall.
REQ-013 mem_req, mem_we and refill SHALL be 0 in every state not listed in REQ-007 to REQ-009.
REQ-014 Read-miss timing: with mem_ready=1 in the first RD_MISS cycle, stall SHALL be high for exactly 3 cycles (IDLE, RD_MISS, FILL).
REQ-015 Each further RD_MISS or WRITE wait cycle SHALL add one stall cycle.
REQ-016 Timeout behaviour:
- A wait counter SHALL clear on entry to RD_MISS or WRITE and increment each cycle in those states.
- If the counter reaches TIMEOUT with mem_ready=0, the FSM SHALL set bus_err=1 and go to DONE, skipping FILL.
- bus_err SHALL stay set until rst.
REQ-017 mem_ready=1 in IDLE, FILL or DONE SHALL be ignored.
REQ-018 miss_cnt SHALL saturate at 2^CNT_W-1.
REQ-019 A store that hits or misses SHALL NOT increment miss_cnt.
REQ-020 A stall of any length SHALL NOT alter miss_cnt beyond the single increment on IDLE exit.

Reset
REQ-021 After rst, the block SHALL be in IDLE with miss_cnt=0, bus_err=0 and wait counter 0.
REQ-022 While rst=1, stall, wb_bubble, mem_req, mem_we and refill SHALL all be 0.
REQ-023 rst asserted mid-transaction SHALL abandon the transaction.
REQ-024 After such an abandon, mem_req SHALL be 0 from the reset cycle onward, and no refill SHALL occur.

Verification
REQ-025 Load hit: mem_read=1, data_hit=1 for 5 cycles -> stall=0 throughout, mem_req=0, miss_cnt=0.
REQ-026 Load miss with mem_ready on the 3rd RD_MISS cycle, then data_hit=1 -> stall high 5 cycles; refill=1 exactly once, in the FILL cycle; stall=0 in DONE; miss_cnt=1.
REQ-027 Store, mem_read=mem_write=1, data_hit=1, mem_ready after 2 cycles -> WRITE path; mem_we=1 with mem_req; stall high 3 cycles; miss_cnt=0; refill=0.
REQ-028 TIMEOUT=4, load miss with mem_ready held 0 -> DONE after 4 RD_MISS cycles; bus_err=1 stays set through later hits; refill never 1.
REQ-029 rst=1 during the 2nd RD_MISS cycle -> all outputs 0 in that cycle; IDLE afterwards; miss_cnt=0; a later late mem_ready is ignored.
REQ-030 CNT_W=2, 5 back-to-back load misses -> miss_cnt reads 1, 2, 3, 3, 3.
